// File: rtl/fib_stream_if.sv
// Request/stream bundle for the generalised-Fibonacci generator.
// Handshake: a term transfers on any rising edge where term_valid && term_ready; while valid is high and ready low, term and term_last hold stable.
interface fib_stream_if #(
  parameter int WIDTH = 16,
  parameter int NW    = 6
);
  logic             start;
  logic [NW-1:0]    n;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic             busy;
  logic [WIDTH-1:0] term;
  logic             term_valid;
  logic             term_ready;
  logic             term_last;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    input  start, n, seed0, seed1, term_ready,
    output busy, term, term_valid, term_last, done, result, ovf
  );

  modport slave (
    output start, n, seed0, seed1, term_ready,
    input  busy, term, term_valid, term_last, done, result, ovf
  );
endinterface

// File: rtl/fib_stream_gen.sv
// Generalised-Fibonacci generator: streams T(0..n) from programmable seeds,
// keeps T(n) in result and flags any carry out of an emitted sum in ovf.
module fib_stream_gen #(
  parameter int WIDTH = 16,
  parameter int NW    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  fib_stream_if.master bus,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [NW-1:0]    n_q;
  logic [NW-1:0]    idx;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic [NW:0]      idx_plus2;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign idx_plus2 = {1'b0, idx} + (NW+1)'(2);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      n_q            <= '0;
      idx            <= '0;
      a              <= '0;
      b              <= '0;
      bus.busy       <= 1'b0;
      bus.term       <= '0;
      bus.term_valid <= 1'b0;
      bus.term_last  <= 1'b0;
      bus.done       <= 1'b0;
      bus.result     <= '0;
      bus.ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            n_q            <= bus.n;
            idx            <= '0;
            a              <= bus.seed0;
            b              <= bus.seed1;
            bus.ovf        <= 1'b0;
            bus.busy       <= 1'b1;
            bus.term       <= bus.seed0;
            bus.term_valid <= 1'b1;
            bus.term_last  <= (bus.n == '0);
            state          <= EMIT;
          end
        end
        EMIT: begin
          if (bus.term_ready) begin
            if (idx == n_q) begin
              bus.result     <= bus.term;
              bus.term       <= '0;
              bus.term_valid <= 1'b0;
              bus.term_last  <= 1'b0;
              bus.busy       <= 1'b0;
              bus.done       <= 1'b1;
              state          <= DONE;
            end else begin
              idx           <= idx + NW'(1);
              bus.term      <= b;
              bus.term_last <= ((idx + NW'(1)) == n_q);
              a             <= b;
              b             <= sum[WIDTH-1:0];
              // The new sum is T(idx+2); it only counts if it will be emitted.
              if (sum[WIDTH] && (idx_plus2 <= {1'b0, n_q}))
                bus.ovf <= 1'b1;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench for fib_stream_gen: a sequence model fills a scoreboard queue,
// one negedge process checks every handshake, done pulse and idle output.
module tb_fib_stream_gen;
  localparam int WIDTH = 16;
  localparam int NW    = 6;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  fib_stream_if #(.WIDTH(WIDTH), .NW(NW)) bus ();

  fib_stream_gen #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [WIDTH-1:0] exp_result;
  logic             exp_ovf;
  logic             expect_done = 1'b0;
  int               hs_count = 0;
  int               hs_first = 0;
  int               hs_last  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sequence model: plain integer recurrence, carry judged on each emitted sum.
  task automatic build(input int nn, input int s0, input int s1);
    int t_prev, t_cur, s;
    exp_q.delete();
    exp_last_q.delete();
    exp_ovf = 1'b0;
    t_prev  = s0;
    t_cur   = s1;
    for (int k = 0; k <= nn; k++) begin
      if (k == 0) s = s0;
      else if (k == 1) s = s1;
      else begin
        s = t_prev + t_cur;
        if (s >= (1 << WIDTH)) exp_ovf = 1'b1;
        s      = s % (1 << WIDTH);
        t_prev = t_cur;
        t_cur  = s;
      end
      exp_q.push_back(WIDTH'(s));
      exp_last_q.push_back(k == nn);
    end
    exp_result = WIDTH'(s);
  endtask

  // compare process
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    logic             l;
    cyc++;
    if (rst_n) begin
      if (expect_done) begin
        chk("done_pulse", bus.done, 1);
        chk("done_busy_low", bus.busy, 0);
        chk("result", bus.result, exp_result);
        chk("ovf", bus.ovf, exp_ovf);
        expect_done = 1'b0;
      end else begin
        chk("done_low", bus.done, 0);
      end
      if (bus.term_valid) begin
        chk("busy_with_valid", bus.busy, 1);
        if (bus.term_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_term", bus.term, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            l = exp_last_q.pop_front();
            chk("term", bus.term, e);
            chk("term_last", bus.term_last, l);
            if (hs_count == 0) hs_first = cyc;
            hs_count++;
            hs_last = cyc;
            if (l) expect_done = 1'b1;
          end
        end
      end else begin
        chk("idle_term_zero", bus.term, 0);
        chk("idle_last_zero", bus.term_last, 0);
      end
    end else begin
      expect_done = 1'b0;
    end
  end

  // driver tasks
  task automatic start_req(input int nn, input int s0, input int s1);
    build(nn, s0, s1);
    hs_count = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n     = NW'(nn);
    bus.seed0 = WIDTH'(s0);
    bus.seed1 = WIDTH'(s1);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_term(input int value, output logic found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.term_valid && bus.term_ready && bus.term == WIDTH'(value)) found = 1'b1;
    end
  endtask

  initial begin
    logic found;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.n          = '0;
    bus.seed0      = '0;
    bus.seed1      = '0;
    bus.term_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.term_valid, 0);
    chk("rst_term", bus.term, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // 1: Fibonacci n=10
    start_req(10, 0, 1);
    chk("model_fib10", exp_result, 55);
    wait_done("fib10");
    chk("fib10_result", bus.result, 55);
    chk("fib10_ovf", bus.ovf, 0);
    chk("fib10_count", hs_count, 11);
    chk("fib10_back_to_back", hs_last - hs_first, 10);
    chk("fib10_idle", dbg_state, 0);

    // 2: Lucas n=5
    start_req(5, 2, 1);
    chk("model_lucas5", exp_result, 11);
    wait_done("lucas5");
    chk("lucas5_result", bus.result, 11);

    // 3: n=0
    start_req(0, 7, 9);
    chk("model_n0", exp_result, 7);
    wait_done("n0");
    chk("n0_result", bus.result, 7);
    chk("n0_count", hs_count, 1);

    // 4: overflow boundary
    start_req(25, 0, 1);
    chk("model_fib25", exp_result, 9489);
    chk("model_fib25_ovf", exp_ovf, 1);
    wait_done("fib25");
    chk("fib25_result", bus.result, 9489);
    chk("fib25_ovf", bus.ovf, 1);
    start_req(24, 0, 1);
    chk("model_fib24", exp_result, 46368);
    chk("model_fib24_ovf", exp_ovf, 0);
    wait_done("fib24");
    chk("fib24_result", bus.result, 46368);
    chk("fib24_ovf", bus.ovf, 0);

    // 5: backpressure on term 5, stray start while busy
    start_req(10, 0, 1);
    wait_term(3, found);
    chk("bp_found_3", found, 1);
    @(posedge clk); #1;
    bus.term_ready = 1'b0;
    bus.start      = 1'b1;
    bus.n          = NW'(3);
    bus.seed0      = WIDTH'(100);
    bus.seed1      = WIDTH'(100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", bus.term_valid, 1);
      chk("bp_term_hold", bus.term, 5);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.term_ready = 1'b1;
    wait_done("bp");
    chk("bp_result", bus.result, 55);
    chk("bp_remaining", exp_q.size(), 0);

    // 6: reset mid-stream at idx=4 (term 3 presented)
    start_req(10, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.term_valid && bus.term == WIDTH'(2)) found = 1'b1;
    end
    chk("rst_mid_found", found, 1);
    @(posedge clk); #1;
    chk("rst_mid_term_idx4", bus.term, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_valid", bus.term_valid, 0);
    chk("rst_mid_term", bus.term, 0);
    chk("rst_mid_last", bus.term_last, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_result", bus.result, 0);
    chk("rst_mid_ovf", bus.ovf, 0);
    chk("rst_mid_state", dbg_state, 0);
    exp_q.delete();
    exp_last_q.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", bus.done, 0);
    start_req(3, 0, 1);
    wait_done("after_rst");
    chk("after_rst_result", bus.result, 2);
    chk("after_rst_count", hs_count, 4);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
